// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational 4-bit ALU, with a single
// backpressured response channel. Define ALU_ARB_FIXED_PRI_EN for fixed req0 priority.
module alu_arbiter #(
    parameter int W      = 4,
    parameter int OPW    = 4,
    parameter int OP_MAX = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_x,
    output logic [W-1:0]   rsp_y,
    output logic           rsp_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_x,
    input  logic [W-1:0]   alu_y
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [OPW-1:0] OP_LIMIT = OPW'(OP_MAX);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(10);

    state_t state, state_nxt;
    logic   grant_any;
    logic   win_id;
    logic   accept;
    logic   id;
    logic   trap;

    assign grant_any = req0_valid | req1_valid;
    assign accept    = (state == IDLE) && grant_any;

`ifdef ALU_ARB_FIXED_PRI_EN
    assign win_id = ~req0_valid;
`else
    logic last_grant;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) win_id = ~last_grant;
        else                          win_id = ~req0_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_grant <= 1'b1;
        else if (accept) last_grant <= win_id;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    // Ready is masked during reset so all outputs read 0 while rst is high.
                    req0_ready = ~rst & ~win_id;
                    req1_ready = ~rst &  win_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign trap = (alu_op > OP_LIMIT) || ((alu_op == OP_DIV) && (alu_b == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            id        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a  <= win_id ? req1_a  : req0_a;
                        alu_b  <= win_id ? req1_b  : req0_b;
                        alu_op <= win_id ? req1_op : req0_op;
                        id     <= win_id;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id;
                    rsp_err   <= trap;
                    rsp_x     <= trap ? '0 : alu_x;
                    rsp_y     <= trap ? '0 : alu_y;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; a small behavioural ALU closes the loop.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [3:0] rsp_x, rsp_y, alu_a, alu_b, alu_op, alu_x, alu_y;

    int total  = 0;
    int passed = 0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_x(alu_x), .alu_y(alu_y)
    );

    always #5 clk = ~clk;

    // Reference ALU; illegal ops and divide-by-zero return nonzero garbage on purpose.
    always_comb begin
        logic [7:0] wide;
        wide  = 8'h00;
        alu_x = 4'hF;
        alu_y = 4'hF;
        case (alu_op)
            4'd0: begin alu_x = alu_a & alu_b;    alu_y = 4'h0; end
            4'd1: begin alu_x = alu_a | alu_b;    alu_y = 4'h0; end
            4'd2: begin alu_x = ~(alu_a & alu_b); alu_y = 4'h0; end
            4'd3: begin alu_x = ~(alu_a | alu_b); alu_y = 4'h0; end
            4'd4: begin alu_x = alu_a ^ alu_b;    alu_y = 4'h0; end
            4'd5: begin alu_x = ~(alu_a ^ alu_b); alu_y = 4'h0; end
            4'd6: begin alu_x = ~alu_a;           alu_y = 4'h0; end
            4'd7: begin wide = {4'h0, alu_a} + {4'h0, alu_b}; alu_x = wide[3:0]; alu_y = {3'b0, wide[4]}; end
            4'd8: begin wide = {4'h0, alu_a} - {4'h0, alu_b}; alu_x = wide[3:0]; alu_y = {3'b0, wide[4]}; end
            4'd9: begin wide = alu_a * alu_b; alu_x = wide[3:0]; alu_y = wide[7:4]; end
            4'd10: begin
                if (alu_b != 4'h0) begin alu_x = alu_a / alu_b; alu_y = alu_a % alu_b; end
                else               begin alu_x = 4'hF;          alu_y = alu_a;         end
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from a single requester; returns with rsp_valid expected high.
    task automatic do_op(input logic who, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        if (!who) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        else      begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        #1;
        check("op_grant", who ? req1_ready : req0_ready, 8'd1);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        check("op_rsp_valid", rsp_valid, 8'd1);
    endtask

    initial begin
        logic exp_id;
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h3; req0_op = 4'h7;
        req1_valid = 1'b0; req1_a = 4'h0; req1_b = 4'h0; req1_op = 4'h0;
        #12;
        check("rst_req0_ready", req0_ready, 8'd0);
        check("rst_rsp_valid", rsp_valid, 8'd0);
        check("rst_alu", {alu_a, alu_op}, 8'h00);
        check("rst_rsp", {rsp_x, rsp_y}, 8'h00);
        req0_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        // Single AND from req0
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'hA; req0_op = 4'h0;
        #1;
        check("and_req0_ready", req0_ready, 8'd1);
        check("and_req1_ready", req1_ready, 8'd0);
        cyc();
        req0_valid = 1'b0;
        check("and_exec_ready", req0_ready, 8'd0);
        check("and_alu_regs", {alu_a, alu_b}, 8'hCA);
        check("and_exec_nvalid", rsp_valid, 8'd0);
        cyc();
        check("and_valid", rsp_valid, 8'd1);
        check("and_id", rsp_id, 8'd0);
        check("and_x", rsp_x, 8'h8);
        check("and_err", rsp_err, 8'd0);
        cyc();
        check("and_done", rsp_valid, 8'd0);

        // Backpressure: req1 SUB 9-6, then req1 keeps a second op pending
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 4'h9; req1_b = 4'h6; req1_op = 4'h8;
        #1;
        check("bp_grant", req1_ready, 8'd1);
        cyc();
        req1_a = 4'hC; req1_b = 4'hA; req1_op = 4'h0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", rsp_valid, 8'd1);
            check("bp_xy", {rsp_x, rsp_y}, 8'h30);
            check("bp_id", rsp_id, 8'd1);
            check("bp_readys", {req0_ready, req1_ready}, 8'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        check("bp_release", rsp_valid, 8'd0);
        check("bp_next_grant", req1_ready, 8'd1);
        cyc();
        req1_valid = 1'b0;
        cyc();
        check("bp_second_x", rsp_x, 8'h8);
        check("bp_second_id", rsp_id, 8'd1);
        cyc();

        // Contention: req0 ADD 5+3, req1 MUL 5*3, both continuously valid
        req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h3; req0_op = 4'h7;
        req1_valid = 1'b1; req1_a = 4'h5; req1_b = 4'h3; req1_op = 4'h9;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            exp_id = 1'b0;
`else
            exp_id = i[0];
`endif
            #1;
            check("cont_ready", {req1_ready, req0_ready}, exp_id ? 8'b10 : 8'b01);
            cyc();
            cyc();
            check("cont_id", rsp_id, {7'b0, exp_id});
            check("cont_xy", {rsp_x, rsp_y}, exp_id ? 8'hF0 : 8'h80);
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Error traps
        do_op(1'b0, 4'h8, 4'h0, 4'hA);
        check("div0_err", rsp_err, 8'd1);
        check("div0_xy", {rsp_x, rsp_y}, 8'h00);
        cyc();
        do_op(1'b0, 4'h3, 4'h5, 4'hF);
        check("opF_err", rsp_err, 8'd1);
        check("opF_xy", {rsp_x, rsp_y}, 8'h00);
        cyc();
        do_op(1'b1, 4'h3, 4'h5, 4'hB);
        check("opB_err", rsp_err, 8'd1);
        cyc();
        do_op(1'b0, 4'h8, 4'h2, 4'hA);
        check("div_err", rsp_err, 8'd0);
        check("div_xy", {rsp_x, rsp_y}, 8'h40);
        cyc();
        do_op(1'b1, 4'h3, 4'h5, 4'h6);
        check("not_x", rsp_x, 8'hC);
        check("not_err", rsp_err, 8'd0);
        cyc();

        // Reset during EXEC after a req0 grant (tie would otherwise favour req1)
        do_op(1'b0, 4'h1, 4'h1, 4'h7);
        cyc();
        req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h3; req0_op = 4'h7;
        #1;
        check("rr_pre_grant", req0_ready, 8'd1);
        cyc();
        req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h2; req1_op = 4'h7;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_alu", {alu_a, alu_b}, 8'h00);
        check("mid_rst_op", alu_op, 8'h0);
        check("mid_rst_readys", {req0_ready, req1_ready}, 8'd0);
        check("mid_rst_valid", rsp_valid, 8'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check("post_rst_nvalid0", rsp_valid, 8'd0);
        cyc();
        check("post_rst_nvalid1", rsp_valid, 8'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("post_rst_tie", {req1_ready, req0_ready}, 8'b01);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        check("post_rst_x", rsp_x, 8'h8);
        check("post_rst_id", rsp_id, 8'd0);
        cyc();
        check("post_rst_done", rsp_valid, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 4-bit `alu` instance between two requesters (req0, req1).
- Each requester uses a valid/ready handshake and submits operands plus an opcode.
- The arbiter grants one request at a time, drives the ALU operand and opcode ports from registers, captures X/Y, and returns a tagged response on a single backpressured response channel.
- Illegal opcodes and divide-by-zero are trapped before reaching the response.

Parameters:
W, 4, operand/result width (must match alu A/B/X/Y width)
OPW, 4, opcode width
OP_MAX, 10, highest legal opcode (0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 ADD, 8 SUB, 9 MUL, 10 DIV/MOD)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a, req0_b  input  W  requester 0 operands
req0_op  input  OPW  requester 0 opcode
req1_valid, req1_ready, req1_a, req1_b, req1_op  as req0, for requester 1
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester index of response
rsp_x, rsp_y  output  W  ALU X/Y results
rsp_err  output  1  illegal opcode or DIV with B=0
alu_a, alu_b  output  W  to alu A/B
alu_op  output  OPW  to alu opcode
alu_x, alu_y  input  W  from alu X/Y

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0, including alu_a/alu_b/alu_op, rsp_* and req*_ready.
  - last_grant=1, so req0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid, select a winner.
  - If only one is valid, it wins.
  - If both are valid, the requester other than last_grant wins (round-robin).
  - reqN_ready=1 combinationally for the winner only, in IDLE only.
  - On that cycle, register a/b/op into alu_a/alu_b/alu_op, record id, update last_grant, go to EXEC.
  - With no valid request, stay in IDLE and hold the alu_* registers.
- EXEC (one cycle; the ALU is combinational):
  - Register rsp_x=alu_x, rsp_y=alu_y, rsp_id=id.
  - Set rsp_err=1 if alu_op>OP_MAX, or if alu_op==10 and alu_b==0.
  - When rsp_err=1, force rsp_x=rsp_y=0.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready, clear rsp_valid and return to IDLE. A new grant is possible on the next cycle.
- Latency and throughput:
  - Accept-to-rsp_valid latency is 2 cycles.
  - Minimum issue interval is 3 cycles per operation.
- Requester rules:
  - req*_ready=0 in EXEC and RESP.
  - A requester must hold valid and its fields until ready. The arbiter never samples unaccepted data.
  - A requester that drops valid before grant loses nothing; no state is kept for it.
- Widths: results pass through unmodified (MUL: X low nibble, Y high nibble; DIV: X quotient, Y remainder). The arbiter performs no arithmetic.
- Reset mid-operation (any state): immediately return to IDLE with all outputs 0. An in-flight operation is dropped and produces no response.
- Simultaneous events: deassertion of a losing requester's valid in the grant cycle has no effect. rsp_ready asserted while not in RESP is ignored.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRI_EN.
- Defined: fixed priority, req0 always wins when both are valid. last_grant is not implemented.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
- Single op, AND: req0 sends A=1100, B=1010, op=0000 with rsp_ready=1 → req0_ready pulses one cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_x=1000, rsp_err=0.
- Contention:
  - Stimulus: both requesters continuously valid; req0 ADD 0101+0011, req1 MUL 0101×0011.
  - Round-robin build: grants alternate 0,1,0,1; responses rsp_x=1000 (ADD) and rsp_x=1111, rsp_y=0000 (MUL).
  - ALU_ARB_FIXED_PRI_EN build: only req0 is granted.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_x/rsp_y/rsp_id stable and both req*_ready=0 throughout; one cycle after rsp_ready=1, rsp_valid=0 and the next grant occurs.
- Error trap:
  - op=1010, A=1000, B=0000 → rsp_err=1, rsp_x=rsp_y=0.
  - op=1111 → rsp_err=1.
  - op=1010, A=1000, B=0010 → rsp_x=0100, rsp_y=0000, rsp_err=0.
- Reset mid-op: assert rst asynchronously during EXEC → all outputs 0 immediately, no rsp_valid after release, and the first grant after release goes to req0 on a tie.
